wb_arb_rr: RTL
==============

# wb_arb_rr

Round-robin arbiter that lets several wishbone masters share the peripheral wishbone bus in the icE1usb top level, the bus that carries misc, GPS UART and I2C. Typical masters are the SoC peripheral master port and an autonomous sequencer, for example an I2C/PLL configurator or a GPS-discipline engine. The arbiter sits between the masters and the existing peripheral decode and forwards exactly one transaction at a time. An optional watchdog terminates transactions that a slave never acknowledges.

## Interface
Parameters:
- `N` (default 2): number of masters, 2..4.
- `AW` (default 16): address width.
- `DW` (default 32): data width.
- `TO_CYCLES` (default 255): watchdog limit in cycles, 1..255. Used only when the watchdog is compiled in.

Ports:
- `clk`  in  1  system clock (`clk_sys`).
- `rst`  in  1  synchronous, active-high reset.
- `m_addr`  in  N*AW  flattened master addresses; master i is at `[i*AW+:AW]`.
- `m_wdata`  in  N*DW  flattened master write data.
- `m_wmsk`  in  N*DW/8  flattened master write byte masks.
- `m_we`  in  N  master write enables.
- `m_cyc`  in  N  master cycle requests.
- `m_ack`  out  N  per-master acknowledge.
- `m_rdata`  out  DW  read data, shared by all masters; valid only with that master's `m_ack`.
- `s_addr`, `s_wdata`, `s_wmsk`, `s_we`, `s_cyc`  out  AW / DW / DW/8 / 1 / 1  slave-side bus.
- `s_rdata`  in  DW  slave read data.
- `s_ack`  in  1  slave acknowledge.
- `gnt`  out  N  one-hot grant, for debug and status.
- `err`  out  1  sticky watchdog flag. Tied to 0 when the watchdog is compiled out.

## Operation
- States:
  - IDLE: no grant.
  - BUSY: one master granted.
- IDLE, any `m_cyc` set:
  - Select the first requesting master at or after pointer `ptr`, wrapping modulo N.
  - Register the selection into `gnt` and go to BUSY.
- BUSY, slave side:
  - `s_cyc = m_cyc[g]`, where g is the granted master.
  - `s_addr`, `s_wdata`, `s_wmsk`, `s_we` are a combinational mux of master g.
- BUSY, acknowledge routing:
  - `m_ack[g] = s_ack`. All other `m_ack` bits are 0.
  - `m_rdata = s_rdata` at all times.
- BUSY -> IDLE on any of:
  - `s_ack` (normal completion).
  - `m_cyc[g]` deasserted without ack (master abort).
  - Watchdog expiry.
- On every BUSY -> IDLE transition: `gnt` clears and `ptr` becomes `(g+1) mod N`.
- Requests never preempt an active grant.
- In IDLE, `s_cyc = 0` and all `m_ack` bits are 0.
- A master that holds `m_cyc` waits. It is guaranteed service within N-1 other transactions.
- Requests that arrive simultaneously are resolved purely by `ptr`.
- A master that re-requests right after its own completion goes to the back of the rotation.

## Timing
- Reset values: state IDLE, `ptr = 0`, `gnt = 0`, `s_cyc = 0`, `m_ack = 0`, `err = 0`, watchdog counter 0.
- Arbitration latency: 1 cycle. `m_cyc` rising in cycle t (bus idle) gives `gnt`/`s_cyc` in cycle t+1.
- Acknowledge path: `s_ack` to `m_ack` is combinational, 0 cycles.
- Slave requirement: `s_ack` is a single-cycle pulse.
- Master requirement: the master drops `m_cyc` in the cycle after its ack. The arbiter is already IDLE in that cycle, so the same request is never granted twice.
- Back-to-back transactions: minimum 2 cycles from one ack to the next `s_cyc` (1 idle cycle plus 1 grant cycle).
- Reset mid-transaction: grant dropped in the next cycle and no ack is generated. The slave sees `s_cyc` fall without completion.

## Configuration
- `WB_ARB_WATCHDOG_EN` defined:
  - An 8-bit counter clears on entry to BUSY and increments every BUSY cycle.
  - When the counter reaches `TO_CYCLES` with no `s_ack`:
    - Drive `m_ack[g] = 1` for one cycle with `m_rdata = 32'hDEADBEEF`.
    - Force `s_cyc = 0` in that cycle.
    - Set `err`, which stays set until `rst`.
    - Return to IDLE.
  - If `s_ack` arrives in the expiry cycle, it wins: a normal ack with slave data is returned.
- `WB_ARB_WATCHDOG_EN` undefined: no counter, `err = 0`, and a hung slave stalls the bus indefinitely.

## Structure
- Shared package `wb_arb_pkg` holds:
  - state encoding constants (`ST_IDLE`, `ST_BUSY`);
  - the timeout data word `32'hDEADBEEF`;
  - the watchdog counter width.
- Sub-module `rr_pick`: combinational round-robin priority selector. Inputs are request vector and pointer; output is a one-hot choice. It is reusable for other shared resources such as the SPI flash/LED path.
- The top level holds the FSM, pointer, muxes and watchdog.

## Test plan
- Single master, N=2, slave acks 3 cycles after `s_cyc`:
  - Master 0 writes `addr 0x0010`, `wdata 0x12345678`.
  - Expect `s_cyc` one cycle after `m_cyc[0]`, `s_addr`/`s_wdata` equal to master 0's values, `m_ack[0]` coincident with `s_ack`, `m_ack[1] = 0`.
- Both masters raise `m_cyc` in the same cycle from reset:
  - Expect master 0 granted first, then master 1.
  - Expect exactly 1 idle cycle between the two transactions and `ptr` back at 0.
- Master 0 requests continuously while master 1 issues 4 requests:
  - Expect the grants to strictly alternate 0,1,0,1, and master 1 never to wait more than one transaction.
- Read by master 1 with `s_rdata = 0xCAFEF00D`:
  - Expect `m_rdata = 0xCAFEF00D` in the `m_ack[1]` cycle.
- Master 0 drops `m_cyc` 2 cycles into BUSY with no ack:
  - Expect return to IDLE and no `m_ack` pulse.
  - Expect a pending master 1 to be granted in the following cycle.
- With `WB_ARB_WATCHDOG_EN`, `TO_CYCLES = 16`, slave that never acks:
  - Expect `m_ack[0]` with `0xDEADBEEF` 16 cycles after the grant, `err = 1` until `rst`, and the next request served normally.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared constants for the wishbone round-robin arbiter
package wb_arb_pkg;
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int          WD_CNT_W        = 8;
    localparam logic [31:0] WD_TIMEOUT_DATA = 32'hDEADBEEF;
endpackage

// File: rtl/wb_arb_rr_pick.sv
// rtl/wb_arb_rr_pick.sv - combinational round-robin picker (module rr_pick)
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  pick_o
);
    logic [N-1:0] rot_req;
    logic [N-1:0] rot_pick;

    // Rotate so the pointer sits at bit 0, isolate the lowest set bit, rotate back.
    assign rot_req  = N'({req_i, req_i} >> ptr_i);
    assign rot_pick = rot_req & (~rot_req + 1'b1);
    assign pick_o   = N'(({rot_pick, rot_pick} << ptr_i) >> N);
endmodule

// File: rtl/wb_arb_rr.sv
// rtl/wb_arb_rr.sv - round-robin wishbone arbiter; WB_ARB_WATCHDOG_EN adds the ack watchdog
module wb_arb_rr
    import wb_arb_pkg::*;
#(
    parameter int N         = 2,
    parameter int AW        = 16,
    parameter int DW        = 32,
    parameter int TO_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*AW-1:0]   m_addr,
    input  logic [N*DW-1:0]   m_wdata,
    input  logic [N*DW/8-1:0] m_wmsk,
    input  logic [N-1:0]      m_we,
    input  logic [N-1:0]      m_cyc,
    output logic [N-1:0]      m_ack,
    output logic [DW-1:0]     m_rdata,
    output logic [AW-1:0]     s_addr,
    output logic [DW-1:0]     s_wdata,
    output logic [DW/8-1:0]   s_wmsk,
    output logic              s_we,
    output logic              s_cyc,
    input  logic [DW-1:0]     s_rdata,
    input  logic              s_ack,
    output logic [N-1:0]      gnt,
    output logic              err
);
    localparam int PW = $clog2(N);

    state_e        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [PW-1:0] gidx_q, gidx_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  pick;
    logic [PW-1:0] pick_idx;
    logic          cyc_g;
    logic          wd_expire;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req_i  (m_cyc),
        .ptr_i  (ptr_q),
        .pick_o (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pick[i]) pick_idx = PW'(i);
        end
    end

    assign cyc_g   = m_cyc[gidx_q];
    assign s_addr  = m_addr[gidx_q*AW +: AW];
    assign s_wdata = m_wdata[gidx_q*DW +: DW];
    assign s_wmsk  = m_wmsk[gidx_q*(DW/8) +: DW/8];
    assign s_we    = m_we[gidx_q];
    assign gnt     = gnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (|m_cyc) begin
                    state_d = ST_BUSY;
                    gnt_d   = pick;
                    gidx_d  = pick_idx;
                end
            end
            ST_BUSY: begin
                // Completion, master abort or timeout all release the bus the same way.
                if (s_ack || !cyc_g || wd_expire) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    ptr_d   = (gidx_q == PW'(N-1)) ? '0 : gidx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_cyc   = 1'b0;
        m_ack   = '0;
        m_rdata = s_rdata;
        if (state_q == ST_BUSY) begin
            s_cyc         = cyc_g && !wd_expire;
            m_ack[gidx_q] = s_ack || wd_expire;
            if (wd_expire) m_rdata = DW'(WD_TIMEOUT_DATA);
        end
    end

`ifdef WB_ARB_WATCHDOG_EN
    logic [WD_CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic                err_q, err_d;

    // A late slave ack in the expiry cycle still wins over the timeout.
    assign wd_expire = (state_q == ST_BUSY) && cyc_g && !s_ack &&
                       (wd_cnt_q == WD_CNT_W'(TO_CYCLES));
    assign err       = err_q;

    always_comb begin
        wd_cnt_d = '0;
        if (state_q == ST_BUSY && state_d == ST_BUSY) wd_cnt_d = wd_cnt_q + 1'b1;
        err_d = err_q | wd_expire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end
`else
    assign wd_expire = 1'b0;
    assign err       = 1'b0;
`endif
endmodule
